// File: rtl/mest_pro_decode_ctrl.sv
// Purpose : MESTPro control sequencer and decode/execute stage (phase strobes, PC control, W/Z).
// Latency : 3 cycles per instruction (FETCH, DECODE, EXEC); DLY K stretches EXEC to K+1 cycles.
// Backpressure: none; the sequencer free-runs once started and only reset aborts a program.
//
// Ports:
//   clk, i_reset_n              core clock, async active-low reset
//   i_start                     run request (level), sampled in IDLE and HALT
//   i_decode_reg                instruction word latched by the fetch stage
//   o_idle/fetch/exec_state     Moore phase strobes (fetch also covers SKIP)
//   o_jump, o_return_pc         PC load / PC restore, EXEC only
//   o_const_K                   K field registered at DECODE
//   o_w, o_zero                 working register and zero flag
//   o_halted, o_illegal         HALT state, undefined-opcode pulse
module mest_pro_decode_ctrl #(
  parameter int INSTRUCTION_SIZE = 16,
  parameter int OP_CODE_SIZE     = 4,
  parameter int CONSTANT_K_SIZE  = 8
) (
  input  logic                       clk,
  input  logic                       i_reset_n,
  input  logic                       i_start,
  input  logic [INSTRUCTION_SIZE-1:0] i_decode_reg,
  output logic                       o_idle_state,
  output logic                       o_fetch_state,
  output logic                       o_exec_state,
  output logic                       o_jump,
  output logic                       o_return_pc,
  output logic [CONSTANT_K_SIZE-1:0] o_const_K,
  output logic [CONSTANT_K_SIZE-1:0] o_w,
  output logic                       o_zero,
  output logic                       o_halted,
  output logic                       o_illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_SKIP,
    S_HALT
  } state_t;

  localparam logic [OP_CODE_SIZE-1:0] OP_JMP  = OP_CODE_SIZE'(4'h1);
  localparam logic [OP_CODE_SIZE-1:0] OP_CALL = OP_CODE_SIZE'(4'h2);
  localparam logic [OP_CODE_SIZE-1:0] OP_RET  = OP_CODE_SIZE'(4'h3);
  localparam logic [OP_CODE_SIZE-1:0] OP_LDI  = OP_CODE_SIZE'(4'h4);
  localparam logic [OP_CODE_SIZE-1:0] OP_ADDI = OP_CODE_SIZE'(4'h5);
  localparam logic [OP_CODE_SIZE-1:0] OP_SUBI = OP_CODE_SIZE'(4'h6);
  localparam logic [OP_CODE_SIZE-1:0] OP_ANDI = OP_CODE_SIZE'(4'h7);
  localparam logic [OP_CODE_SIZE-1:0] OP_ORI  = OP_CODE_SIZE'(4'h8);
  localparam logic [OP_CODE_SIZE-1:0] OP_XORI = OP_CODE_SIZE'(4'h9);
  localparam logic [OP_CODE_SIZE-1:0] OP_SKZ  = OP_CODE_SIZE'(4'hA);
  localparam logic [OP_CODE_SIZE-1:0] OP_DLY  = OP_CODE_SIZE'(4'hB);
  localparam logic [OP_CODE_SIZE-1:0] OP_UD0  = OP_CODE_SIZE'(4'hC);
  localparam logic [OP_CODE_SIZE-1:0] OP_UD1  = OP_CODE_SIZE'(4'hD);
  localparam logic [OP_CODE_SIZE-1:0] OP_UD2  = OP_CODE_SIZE'(4'hE);
  localparam logic [OP_CODE_SIZE-1:0] OP_HALT = OP_CODE_SIZE'(4'hF);

  state_t                     state_q, state_d;
  logic [OP_CODE_SIZE-1:0]    opcode_q;
  logic [CONSTANT_K_SIZE-1:0] k_q;
  logic [CONSTANT_K_SIZE-1:0] cnt_q;
  logic [CONSTANT_K_SIZE-1:0] w_q;
  logic                       z_q;

  logic [CONSTANT_K_SIZE-1:0] alu_res;
  logic                       alu_wr;
  logic                       in_exec;

  // Bits between opcode and K carry no meaning for this core.
  logic unused_bits;
  assign unused_bits = ^i_decode_reg[INSTRUCTION_SIZE-OP_CODE_SIZE-1:CONSTANT_K_SIZE];

  assign in_exec = (state_q == S_EXEC);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (opcode_q == OP_SKZ && z_q)                             state_d = S_SKIP;
        else if (opcode_q == OP_DLY && cnt_q != '0)                state_d = S_EXEC;
        else if (opcode_q == OP_HALT)                              state_d = S_HALT;
      end
      S_SKIP:   state_d = S_FETCH;
      S_HALT:   if (!i_start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ALU: only opcodes 4..9 write W and Z
  always_comb begin
    alu_res = w_q;
    alu_wr  = 1'b1;
    case (opcode_q)
      OP_LDI:  alu_res = k_q;
      OP_ADDI: alu_res = w_q + k_q;
      OP_SUBI: alu_res = w_q - k_q;
      OP_ANDI: alu_res = w_q & k_q;
      OP_ORI:  alu_res = w_q | k_q;
      OP_XORI: alu_res = w_q ^ k_q;
      default: alu_wr  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      w_q      <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= i_decode_reg[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
        k_q      <= i_decode_reg[CONSTANT_K_SIZE-1:0];
        cnt_q    <= i_decode_reg[CONSTANT_K_SIZE-1:0];
      end
      if (in_exec && opcode_q == OP_DLY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (in_exec && alu_wr) begin
        w_q <= alu_res;
        z_q <= (alu_res == '0);
      end
    end
  end

  assign o_idle_state  = (state_q == S_IDLE);
  assign o_fetch_state = (state_q == S_FETCH) || (state_q == S_SKIP);
  assign o_exec_state  = in_exec;
  assign o_halted      = (state_q == S_HALT);
  assign o_jump        = in_exec && (opcode_q == OP_JMP || opcode_q == OP_CALL);
  assign o_return_pc   = in_exec && (opcode_q == OP_RET);
  assign o_illegal     = in_exec && (opcode_q == OP_UD0 || opcode_q == OP_UD1 ||
                                     opcode_q == OP_UD2);
  assign o_const_K     = k_q;
  assign o_w           = w_q;
  assign o_zero        = z_q;

endmodule

// File: tb/tb_mest_pro_decode_ctrl.sv
// Bench for mest_pro_decode_ctrl: issues a directed instruction program, pushes the
// expected EXEC-cycle response per instruction into a queue, and a negedge monitor
// pops and compares every time the DUT is in EXEC.
module tb_mest_pro_decode_ctrl;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic [15:0] i_decode_reg;
  logic        o_idle_state, o_fetch_state, o_exec_state;
  logic        o_jump, o_return_pc, o_zero, o_halted, o_illegal;
  logic [7:0]  o_const_K, o_w;

  mest_pro_decode_ctrl #(
    .INSTRUCTION_SIZE(16),
    .OP_CODE_SIZE(4),
    .CONSTANT_K_SIZE(8)
  ) dut (
    .clk(clk),
    .i_reset_n(i_reset_n),
    .i_start(i_start),
    .i_decode_reg(i_decode_reg),
    .o_idle_state(o_idle_state),
    .o_fetch_state(o_fetch_state),
    .o_exec_state(o_exec_state),
    .o_jump(o_jump),
    .o_return_pc(o_return_pc),
    .o_const_K(o_const_K),
    .o_w(o_w),
    .o_zero(o_zero),
    .o_halted(o_halted),
    .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jmp;
    logic       ret;
    logic       ill;
    logic [7:0] kk;
    logic [7:0] w;
    logic       z;
    logic       first;
    int         nf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fcnt  = 0;

  // Reference model state
  logic [7:0] mw = 8'h00;
  logic       mz = 1'b0;
  int         next_nf = 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mw      = 8'h00;
    mz      = 1'b0;
    next_nf = 1;
  endfunction

  function automatic void push_expect(input logic [3:0] op, input logic [7:0] k);
    exp_t e;
    int   n;
    n = (op == 4'hB) ? int'(k) + 1 : 1;
    for (int i = 0; i < n; i++) begin
      e.jmp   = (op == 4'h1) || (op == 4'h2);
      e.ret   = (op == 4'h3);
      e.ill   = (op >= 4'hC) && (op <= 4'hE);
      e.kk    = k;
      e.w     = mw;
      e.z     = mz;
      e.first = (i == 0);
      e.nf    = next_nf;
      q.push_back(e);
    end
    case (op)
      4'h4: mw = k;
      4'h5: mw = mw + k;
      4'h6: mw = mw - k;
      4'h7: mw = mw & k;
      4'h8: mw = mw | k;
      4'h9: mw = mw ^ k;
      default: ;
    endcase
    if (op >= 4'h4 && op <= 4'h9) mz = (mw == 8'h00);
    next_nf = (op == 4'hA && mz) ? 2 : 1;
  endfunction

  // Acts as the fetch stage: presents the word during FETCH, returns at first EXEC cycle.
  task automatic issue(input logic [3:0] op, input logic [7:0] k);
    int t;
    t = 0;
    while (!o_fetch_state && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_fetch_state) begin
      n_cmp++; n_err++;
      $display("FAIL fetch_timeout: op %0h got no fetch within 50 cycles", op);
    end
    i_decode_reg = {op, 4'h5, k};
    push_expect(op, k);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_exec_state && t < 50);
    if (!o_exec_state) begin
      n_cmp++; n_err++;
      $display("FAIL exec_timeout: op %0h got no exec within 50 cycles", op);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!i_reset_n) begin
      fcnt = 0;
    end else begin
      if (o_fetch_state) fcnt++;
      chk("onehot_strobes", 32'(o_idle_state) + 32'(o_fetch_state) + 32'(o_exec_state) + 32'(o_halted) <= 1, 1);
      if (o_exec_state) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_exec: exec seen with empty queue (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("jump",      o_jump,      e.jmp);
          chk("return_pc", o_return_pc, e.ret);
          chk("illegal",   o_illegal,   e.ill);
          chk("const_K",   o_const_K,   e.kk);
          chk("w",         o_w,         e.w);
          chk("zero",      o_zero,      e.z);
          if (e.first) chk("fetch_run", fcnt, e.nf);
        end
        fcnt = 0;
      end
    end
  end

  initial begin
    i_reset_n    = 1'b0;
    i_start      = 1'b0;
    i_decode_reg = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_idle",   o_idle_state,  1'b1);
    chk("rst_fetch",  o_fetch_state, 1'b0);
    chk("rst_exec",   o_exec_state,  1'b0);
    chk("rst_halted", o_halted,      1'b0);
    chk("rst_jump",   o_jump,        1'b0);
    chk("rst_w",      o_w,           8'h00);
    chk("rst_zero",   o_zero,        1'b0);
    chk("rst_K",      o_const_K,     8'h00);

    // First NOP driven by hand to check the exact phase sequence after start
    model_reset();
    push_expect(4'h0, 8'h00);
    i_reset_n = 1'b1;
    i_start   = 1'b1;
    @(negedge clk);
    chk("first_fetch", o_fetch_state, 1'b1);
    chk("first_fetch_idle", o_idle_state, 1'b0);
    @(negedge clk);
    chk("decode_strobes", {o_idle_state, o_fetch_state, o_exec_state, o_halted}, 4'b0000);
    @(negedge clk);
    chk("first_exec", o_exec_state, 1'b1);

    issue(4'h0, 8'h00);
    issue(4'h0, 8'h00);

    // Arithmetic and zero flag
    issue(4'h4, 8'hF0);
    issue(4'h5, 8'h10);
    @(negedge clk);
    chk("addi_w", o_w, 8'h00);
    chk("addi_z", o_zero, 1'b1);
    issue(4'h6, 8'h01);
    @(negedge clk);
    chk("subi_w", o_w, 8'hFF);
    chk("subi_z", o_zero, 1'b0);
    issue(4'h9, 8'hFF);
    @(negedge clk);
    chk("xori_w", o_w, 8'h00);
    chk("xori_z", o_zero, 1'b1);
    issue(4'h8, 8'h0C);
    issue(4'h7, 8'h0A);

    // Program flow
    issue(4'h1, 8'h20);
    issue(4'h2, 8'h40);
    issue(4'h3, 8'h00);

    // SKZ taken, then not taken
    issue(4'h4, 8'h00);
    issue(4'hA, 8'h00);
    issue(4'h0, 8'h00);
    issue(4'h4, 8'h05);
    issue(4'hA, 8'h00);
    issue(4'h0, 8'h00);

    // Delay
    issue(4'hB, 8'h03);
    issue(4'hB, 8'h00);
    issue(4'h0, 8'h00);

    // Undefined opcode leaves W alone
    issue(4'hC, 8'h77);
    issue(4'h0, 8'h00);

    // HALT
    issue(4'hF, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("halted_hold", o_halted, 1'b1);
    end
    i_start = 1'b0;
    @(negedge clk);
    chk("halt_to_idle", o_idle_state, 1'b1);
    chk("halt_off",     o_halted,     1'b0);
    i_start = 1'b1;

    // Async reset in the middle of a long EXEC
    issue(4'h4, 8'h33);
    issue(4'hB, 8'h0A);
    @(negedge clk);
    #2 i_reset_n = 1'b0;
    #1;
    chk("async_rst_idle", o_idle_state, 1'b1);
    chk("async_rst_exec", o_exec_state, 1'b0);
    chk("async_rst_w",    o_w,          8'h00);
    q.delete();
    model_reset();
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_idle", o_idle_state, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
